// File: rtl/udma_jtag_pkg.sv
// Shared definitions for the uDMA JTAG receive packer: item size codes,
// the word-buffer entry type and small helpers used by the packer datapath.
package udma_jtag_pkg;

  localparam logic [1:0] SIZE_8B  = 2'b00;
  localparam logic [1:0] SIZE_16B = 2'b01;
  localparam logic [1:0] SIZE_32B = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } rx_entry_t;

  // Item size code to byte count; the unused code 11 behaves like 32-bit.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_8B:  n = 3'd1;
      SIZE_16B: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // Byte enables for lanes 0..cnt-1 of a partially filled word.
  function automatic logic [3:0] lane_mask(input logic [1:0] cnt);
    logic [3:0] m;
    case (cnt)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/udma_jtag_rx_fifo.sv
// Generic synchronous show-ahead FIFO. The head entry is presented whenever
// the FIFO is non-empty and reads as zero when empty. Pointers carry an
// extra wrap bit so full and empty are distinguishable at any fill level.
import udma_jtag_pkg::*;

module udma_jtag_rx_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rx_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + (do_push ? (AW+1)'(1) : (AW+1)'(0));
    rd_ptr_d = rd_ptr_q + (do_pop  ? (AW+1)'(1) : (AW+1)'(0));
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; storage contents are masked while empty so need no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage written at the tail slot.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end
  end

endmodule

// File: rtl/udma_jtag_rx_packer.sv
// Packs 8/16/32-bit JTAG receive items little-endian into 32-bit words with
// byte enables and buffers them for the clock-domain-crossing FIFO.
// Optional feature macro: UDMA_JTAG_RX_OVFCNT_EN adds the saturating
// dropped-word counter on ovf_cnt_o.
import udma_jtag_pkg::*;

module udma_jtag_rx_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        jtag_tck_i,
  input  logic        jtag_trstn_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic [1:0]  size_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        ovf_o,
  input  logic        ovf_clr_i
`ifdef UDMA_JTAG_RX_OVFCNT_EN
  ,
  output logic [7:0]  ovf_cnt_o
`endif
);

  logic [31:0] pack_q, pack_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [3:0]  pend_be_q, pend_be_d;
  logic        ovf_q, ovf_d;

  logic [2:0]  n_bytes;
  logic [2:0]  fill_sum;
  logic [31:0] item;
  logic [31:0] merged;
  logic [31:0] pack_mid;
  logic [1:0]  cnt_mid;
  logic        push;
  rx_entry_t   push_entry;
  logic        viol;

  rx_entry_t   head;
  logic        fifo_empty, fifo_full;
  logic        pop;
  logic        word_drop;

  // Packer datapath: a pending word always goes out first; otherwise the
  // item is merged, then a flush emits or defers whatever partial word remains.
  always_comb begin
    n_bytes = size_bytes(size_i);
    case (n_bytes)
      3'd1:    item = data_i & 32'h0000_00FF;
      3'd2:    item = data_i & 32'h0000_FFFF;
      default: item = data_i;
    endcase
    fill_sum = {1'b0, cnt_q} + n_bytes;
    merged   = pack_q | (item << {cnt_q, 3'b000});

    pack_d     = pack_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_be_d  = pend_be_q;
    pack_mid   = pack_q;
    cnt_mid    = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    viol       = 1'b0;

    if (pend_q) begin
      push            = 1'b1;
      push_entry.data = pack_q;
      push_entry.be   = pend_be_q;
      pend_d          = 1'b0;
      pack_d          = 32'h0;
      cnt_d           = 2'd0;
      viol            = valid_i;
    end else begin
      if (valid_i) begin
        if (fill_sum < 3'd4) begin
          pack_mid = merged;
          cnt_mid  = fill_sum[1:0];
        end else if (fill_sum == 3'd4) begin
          push            = 1'b1;
          push_entry.data = merged;
          push_entry.be   = 4'b1111;
          pack_mid        = 32'h0;
          cnt_mid         = 2'd0;
        end else begin
          push            = 1'b1;
          push_entry.data = pack_q;
          push_entry.be   = lane_mask(cnt_q);
          pack_mid        = item;
          if (n_bytes == 3'd4) begin
            pend_d    = 1'b1;
            pend_be_d = 4'b1111;
            cnt_mid   = 2'd0;
          end else begin
            cnt_mid   = n_bytes[1:0];
          end
        end
      end
      pack_d = pack_mid;
      cnt_d  = cnt_mid;
      if (flush_i && (cnt_mid != 2'd0)) begin
        if (!push) begin
          push            = 1'b1;
          push_entry.data = pack_mid;
          push_entry.be   = lane_mask(cnt_mid);
          pack_d          = 32'h0;
          cnt_d           = 2'd0;
        end else begin
          pend_d    = 1'b1;
          pend_be_d = lane_mask(cnt_mid);
          cnt_d     = 2'd0;
        end
      end
    end
  end

  // Drop detection and sticky overflow flag; a new drop beats a clear.
  always_comb begin
    pop       = valid_o && ready_i;
    word_drop = push && fifo_full && !pop;
    ovf_d     = ovf_clr_i ? 1'b0 : ovf_q;
    if (word_drop || viol) begin
      ovf_d = 1'b1;
    end
  end

  // Packer and overflow state registers.
  always_ff @(posedge jtag_tck_i) begin
    if (!jtag_trstn_i) begin
      pack_q    <= 32'h0;
      cnt_q     <= 2'd0;
      pend_q    <= 1'b0;
      pend_be_q <= 4'b0000;
      ovf_q     <= 1'b0;
    end else begin
      pack_q    <= pack_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_be_q <= pend_be_d;
      ovf_q     <= ovf_d;
    end
  end

  udma_jtag_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rx_entry_t)
  ) u_fifo (
    .clk_i   (jtag_tck_i),
    .rst_ni  (jtag_trstn_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Output port mapping from the FIFO head.
  always_comb begin
    valid_o = !fifo_empty;
    data_o  = head.data;
    be_o    = head.be;
    ovf_o   = ovf_q;
  end

`ifdef UDMA_JTAG_RX_OVFCNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [1:0] drop_inc;
  logic [8:0] cnt_sum;

  // Saturating dropped-item counter; a clear coinciding with drops leaves 1.
  always_comb begin
    drop_inc = {1'b0, word_drop} + {1'b0, viol};
    cnt_sum  = {1'b0, ovf_cnt_q} + {7'b0, drop_inc};
    if (ovf_clr_i) begin
      ovf_cnt_d = (drop_inc != 2'd0) ? 8'd1 : 8'd0;
    end else begin
      ovf_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  // Counter register.
  always_ff @(posedge jtag_tck_i) begin
    if (!jtag_trstn_i) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_udma_jtag_rx_packer.sv
// Directed, table-driven bench for udma_jtag_rx_packer. Each vector drives
// one cycle of inputs and lists the outputs expected just after that edge.
// Counter checks are active when UDMA_JTAG_RX_OVFCNT_EN is defined.
module tb_udma_jtag_rx_packer;

  logic        jtag_tck_i = 1'b0;
  logic        jtag_trstn_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic        valid_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        ovf_clr_i = 1'b0;
  logic [31:0] data_o;
  logic [3:0]  be_o;
  logic        valid_o;
  logic        ovf_o;
`ifdef UDMA_JTAG_RX_OVFCNT_EN
  logic [7:0]  ovf_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [1:0]  size;
    logic [31:0] data;
    logic        flush;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] words [6];

  udma_jtag_rx_packer #(.FIFO_DEPTH(4)) dut (
    .jtag_tck_i   (jtag_tck_i),
    .jtag_trstn_i (jtag_trstn_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .size_i       (size_i),
    .flush_i      (flush_i),
    .data_o       (data_o),
    .be_o         (be_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .ovf_o        (ovf_o),
    .ovf_clr_i    (ovf_clr_i)
`ifdef UDMA_JTAG_RX_OVFCNT_EN
    ,
    .ovf_cnt_o    (ovf_cnt_o)
`endif
  );

  always #5 jtag_tck_i = ~jtag_tck_i;

  function automatic vec_t mk(input logic rst_n, input logic valid, input logic [1:0] size,
                              input logic [31:0] data, input logic flush, input logic ready,
                              input logic clr, input logic exp_valid, input logic [31:0] exp_data,
                              input logic [3:0] exp_be, input logic exp_ovf);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.size = size; v.data = data;
    v.flush = flush; v.ready = ready; v.clr = clr;
    v.exp_valid = exp_valid; v.exp_data = exp_data; v.exp_be = exp_be; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic valid, input logic [1:0] size,
                               input logic [31:0] data, input logic flush, input logic ready,
                               input logic clr);
    @(negedge jtag_tck_i);
    jtag_trstn_i = rst_n;
    valid_i      = valid;
    size_i       = size;
    data_i       = data;
    flush_i      = flush;
    ready_i      = ready;
    ovf_clr_i    = clr;
    @(posedge jtag_tck_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic exp_valid, input logic [31:0] exp_data,
                          input logic [3:0] exp_be, input logic exp_ovf);
    checkOutput({tag, ".valid"}, {31'b0, valid_o}, {31'b0, exp_valid});
    checkOutput({tag, ".data"}, data_o, exp_data);
    checkOutput({tag, ".be"}, {28'b0, be_o}, {28'b0, exp_be});
    checkOutput({tag, ".ovf"}, {31'b0, ovf_o}, {31'b0, exp_ovf});
  endtask

  task automatic idle(input logic ready, input logic clr);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, ready, clr);
  endtask

  initial begin
    // Reset and four bytes forming one word
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h11,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h22,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h33,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h44,       0, 1, 0, 1, 32'h44332211, 4'hF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Byte then misfitting 32-bit item: partial word, then deferred full word
    vecs.push_back(mk(1, 1, 2'b00, 32'hFFFFFFAA, 0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b10, 32'hDEADBEEF, 0, 1, 0, 1, 32'h000000AA, 4'h1, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 1, 32'hDEADBEEF, 4'hF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // 16-bit item then flush
    vecs.push_back(mk(1, 1, 2'b01, 32'hABCD1234, 0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        1, 1, 0, 1, 32'h00001234, 4'h3, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Completing byte with flush in the same cycle: single full word only
    vecs.push_back(mk(1, 1, 2'b00, 32'h33,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h22,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h11,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h55,       1, 1, 0, 1, 32'h55112233, 4'hF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Misfitting 16-bit item with flush: remainder goes out one cycle later
    vecs.push_back(mk(1, 1, 2'b00, 32'h01,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h02,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h03,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 32'h0000BBAA, 1, 1, 0, 1, 32'h00030201, 4'h7, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 1, 32'h0000BBAA, 4'h3, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Flush with nothing packed is a no-op
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 0));
    // Reset mid-pack discards the partial word
    vecs.push_back(mk(1, 1, 2'b01, 32'h0000BEEF, 0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h0000007E, 1, 1, 0, 1, 32'h0000007E, 4'h1, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Two halfwords, and size code 11 behaving as 32-bit
    vecs.push_back(mk(1, 1, 2'b01, 32'h00005678, 0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 32'hFFFF1234, 0, 1, 0, 1, 32'h12345678, 4'hF, 0));
    vecs.push_back(mk(1, 1, 2'b11, 32'hCAFEF00D, 0, 1, 0, 1, 32'hCAFEF00D, 4'hF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0));
    // Item arriving while a deferred word is pending is dropped as overflow
    vecs.push_back(mk(1, 1, 2'b00, 32'h01,       0, 1, 0, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b10, 32'h0A0B0C0D, 0, 1, 0, 1, 32'h00000001, 4'h1, 0));
    vecs.push_back(mk(1, 1, 2'b00, 32'h99,       0, 1, 0, 1, 32'h0A0B0C0D, 4'hF, 1));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 1, 1, 0, 32'h0,        4'h0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].size, vecs[i].data,
                    vecs[i].flush, vecs[i].ready, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
               vecs[i].exp_be, vecs[i].exp_ovf);
    end
`ifdef UDMA_JTAG_RX_OVFCNT_EN
    checkOutput("cnt_after_table", {24'b0, ovf_cnt_o}, 32'd0);
`endif

    // Overflow: consumer stalled, five words into a four-entry buffer
    words[0] = 32'hA0A0A0A0; words[1] = 32'hB1B1B1B1; words[2] = 32'hC2C2C2C2;
    words[3] = 32'hD3D3D3D3; words[4] = 32'hE4E4E4E4; words[5] = 32'hF5F5F5F5;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, words[i], 1'b0, 1'b0, 1'b0);
      checkAll($sformatf("fill%0d", i), 1'b1, words[0], 4'hF, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 2'b10, words[4], 1'b0, 1'b0, 1'b0);
    checkAll("drop5", 1'b1, words[0], 4'hF, 1'b1);
`ifdef UDMA_JTAG_RX_OVFCNT_EN
    checkOutput("cnt_drop5", {24'b0, ovf_cnt_o}, 32'd1);
`endif
    applyStimulus(1'b1, 1'b1, 2'b10, words[5], 1'b0, 1'b0, 1'b1);
    checkAll("drop_with_clr", 1'b1, words[0], 4'hF, 1'b1);
`ifdef UDMA_JTAG_RX_OVFCNT_EN
    checkOutput("cnt_drop_with_clr", {24'b0, ovf_cnt_o}, 32'd1);
`endif
    idle(1'b0, 1'b0);
    checkAll("stall_hold", 1'b1, words[0], 4'hF, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1, 1'b0);
      if (k < 4) checkAll($sformatf("drain%0d", k), 1'b1, words[k], 4'hF, 1'b1);
      else       checkAll("drain_empty", 1'b0, 32'h0, 4'h0, 1'b1);
    end
    idle(1'b1, 1'b1);
    checkAll("ovf_clear", 1'b0, 32'h0, 4'h0, 1'b0);
`ifdef UDMA_JTAG_RX_OVFCNT_EN
    checkOutput("cnt_clear", {24'b0, ovf_cnt_o}, 32'd0);

    // Saturation: fill the buffer, then force 260 drops
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 32'h12340000 + i, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 32'h55550000 + i, 1'b0, 1'b0, 1'b0);
      if (i == 254) checkOutput("cnt_at_255", {24'b0, ovf_cnt_o}, 32'd255);
    end
    checkOutput("cnt_saturated", {24'b0, ovf_cnt_o}, 32'd255);
    checkAll("sat_head", 1'b1, 32'h12340000, 4'hF, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("cnt_sat_clear", {24'b0, ovf_cnt_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udma_jtag_rx_packer.md
# udma_jtag_rx_packer

Receive-side packing stage that sits directly downstream of the uDMA JTAG FIFO shift state machine, in the TCK domain. It accepts the zero-extended 8/16/32-bit items that the state machine emits as single-cycle pulses without backpressure. It packs them little-endian into 32-bit words with byte enables and buffers the words in a small FIFO. A valid/ready port toward the clock-domain-crossing FIFO drains that buffer, and overflow is reported.

## Interface
- FIFO_DEPTH, 4: word buffer entries; power of two, ≥2
- jtag_tck_i  in  1  clock; all logic on rising edge
- jtag_trstn_i  in  1  reset; one clock; reset is synchronous and active-low
- data_i  in  32  received item, zero-extended, valid bits in [8·n-1:0]
- valid_i  in  1  single-cycle item strobe; no backpressure, never stalled
- size_i  in  2  item size with valid_i: 00=8b, 01=16b, 10=32b, 11 treated as 32b
- flush_i  in  1  end of DR scan (update_dr): emit any partial word
- data_o  out  32  head word
- be_o  out  4  head word byte enables, contiguous from lane 0
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts head when valid_o
- ovf_o  out  1  sticky: a word was dropped on full FIFO
- ovf_clr_i  in  1  clears ovf_o
- ovf_cnt_o  out  8  dropped-word count (only with macro, see Configuration)

## Operation
- Packer state: pack_q[31:0], cnt_q (bytes filled, 0..3), pend_q, pend_be_q[3:0].
- Item of n bytes (1/2/4) at valid_i:
  - cnt_q+n<4: write item bytes into lanes cnt_q..cnt_q+n-1; cnt_q += n.
  - cnt_q+n==4: push {merged word, 1111}; cnt_q=0, pack_q=0.
  - cnt_q+n>4 (misfit): push {pack_q, be of lanes 0..cnt_q-1}; place item at lane 0; cnt_q=n (n<4), or for n=4 set pend_q with pend_be_q=1111 and cnt_q=0.
- flush_i with cnt_q>0: push partial word, be = lanes 0..cnt_q-1; cnt_q=0. flush_i with cnt_q==0: no-op.
- valid_i and flush_i in the same cycle: item is processed first. If that yields a push and a partial remainder still exists, the remainder moves to pend_q/pend_be_q for the next cycle.
- pend_q set: that cycle pushes {pack_q, pend_be_q} and clears pend_q. A valid_i arriving while pend_q is set is a protocol violation; the item is dropped and counted as overflow. The upstream spaces items ≥8 cycles apart, so this does not occur in normal operation.
- Push into the FIFO is accepted if not full, or if full with a pop in the same cycle. Otherwise the word is discarded, ovf_o←1, and packer state advances as if the push had been accepted.
- ovf_clr_i clears ovf_o. If a drop occurs in the same cycle, the set wins.
- Unused high bits of data_i above item size are ignored.

## Timing
- Reset (sync, jtag_trstn_i low at edge): FIFO empty, pack_q=0, cnt_q=0, pend_q=0. Outputs: valid_o=0, data_o=0, be_o=0, ovf_o=0, ovf_cnt_o=0. A reset mid-pack discards the partial word silently.
- Latency: an item completing a word at edge k makes valid_o=1 after edge k (one cycle) when the FIFO was empty. A pend_q word appears one cycle later.
- Show-ahead FIFO: data_o/be_o are stable while valid_o && !ready_i. Pop on valid_o && ready_i. data_o/be_o read 0 when empty.
- Throughput: one push and one pop per cycle. Pointers wrap modulo FIFO_DEPTH; full/empty use an extra wrap bit.

## Configuration
- UDMA_JTAG_RX_OVFCNT_EN defined: ovf_cnt_o present. It is an 8-bit saturating count (stops at 255) of dropped words and dropped pend-violation items, and ovf_clr_i zeroes it. If a drop and ovf_clr_i coincide, the result is 1.
- Undefined: port ovf_cnt_o and the counter are absent; ovf_o is unchanged.

## Structure
- udma_jtag_pkg: size encodings (SIZE_8B/16B/32B), typedef of the FIFO entry struct {data[31:0], be[3:0]}, and a function mapping size to byte count.
- Sub-module udma_jtag_rx_fifo: generic synchronous show-ahead FIFO with synchronous active-low reset, parameter DEPTH, typed entry.

## Test plan
- 8b items 0x11, 0x22, 0x33, 0x44, ready_i=1 -> one word 0x44332211, be 1111, valid_o one cycle after the fourth strobe.
- 8b 0xAA then 32b 0xDEADBEEF -> word 0x000000AA be 0001, then next cycle 0xDEADBEEF be 1111.
- 16b 0x1234 then flush_i -> 0x00001234 be 0011. 8b 0x55 with flush_i in the same cycle at cnt_q=3 (lanes 0x112233) -> 0x55112233 be 1111, no extra word.
- ready_i=0, push 5 full words with FIFO_DEPTH=4 -> first 4 retained in order, 5th dropped, ovf_o=1 (ovf_cnt_o=1 with macro). ovf_clr_i -> 0.
- Pack 16b 0xBEEF (cnt_q=2), pulse jtag_trstn_i low one cycle, then 8b 0x7E + flush -> only 0x0000007E be 0001.
- 256+ forced drops with macro -> ovf_cnt_o saturates at 255.
